// File: rtl/seq_divmod_pkg.sv
// Shared definitions for the sequential divide/modulo unit: FSM states,
// default operand width and the quotient returned on divide by zero.
package seq_divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

  // Wide enough for any supported WIDTH; users take the low WIDTH bits.
  localparam logic [63:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divmod_if.sv
// Request/result bundle between the ALU (master) and seq_divmod (slave).
// Optional macro SEQ_DIVMOD_SIGNED_EN adds the signed_mode request bit.
interface seq_divmod_if
  import seq_divmod_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIVMOD_SIGNED_EN
  logic             signed_mode;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

`ifdef SEQ_DIVMOD_SIGNED_EN
  modport master (output start, dividend, divisor, signed_mode,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor, signed_mode,
                  output busy, done, quotient, remainder, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
`endif

endinterface

// File: rtl/seq_divmod_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
module divmod_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] diff;
  logic             carry;

  // The trial difference is WIDTH+1 bits: the bit shifted out of r_in is
  // the top bit of the shifted remainder, and when it is set the divisor
  // always fits, so it is ORed with the carry out of the low subtraction.
  always_comb begin
    shifted        = {r_in[WIDTH-2:0], bit_in};
    {carry, diff}  = {1'b0, shifted} + {1'b0, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
    q_bit          = r_in[WIDTH-1] | carry;
    r_out          = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/seq_divmod.sv
// Multi-cycle restoring divider returning quotient and remainder together.
// One step per clock under a start/done handshake; results held until the
// next operation completes. Macro SEQ_DIVMOD_SIGNED_EN enables
// two's-complement operation selected per request by signed_mode.
module seq_divmod
  import seq_divmod_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       Clock,
  input  logic       Reset,
  seq_divmod_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             dz_pend;
  logic             busy_r, done_r, dbz_r;
  logic [WIDTH-1:0] quo_r, rem_r;

  // Working registers: dvd_w shifts the dividend out of its MSB while the
  // quotient bits fill in from its LSB.
  logic [WIDTH-1:0] rem_w, dvd_w, dsr_w;
  logic             neg_q, neg_r;

  logic             sgn;
  logic             accept;
  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic [WIDTH-1:0] q_next;

`ifdef SEQ_DIVMOD_SIGNED_EN
  assign sgn = bus.signed_mode;
`else
  assign sgn = 1'b0;
`endif

  // Two's-complement magnitude when signed operation is requested.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic en);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

  // Conditional negation used for the final sign fix-up.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic en);
    return en ? -v : v;
  endfunction

  assign accept = bus.start && !dz_pend && (state == IDLE || state == DONE);

  divmod_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (rem_w),
    .bit_in  (dvd_w[WIDTH-1]),
    .divisor (dsr_w),
    .r_out   (step_r),
    .q_bit   (step_q)
  );

  assign q_next = {dvd_w[WIDTH-2:0], step_q};

  // Operand capture and one restoring step per CALC cycle (data, no reset).
  always_ff @(posedge Clock) begin
    if (accept) begin
      dsr_w <= magnitude(bus.divisor, sgn);
      // A zero divisor keeps the raw dividend: it becomes the remainder.
      dvd_w <= (bus.divisor == '0) ? bus.dividend : magnitude(bus.dividend, sgn);
      rem_w <= '0;
      neg_q <= sgn && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      neg_r <= sgn && bus.dividend[WIDTH-1];
    end else if (state == CALC) begin
      rem_w <= step_r;
      dvd_w <= q_next;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dz_pend <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      quo_r   <= '0;
      rem_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (dz_pend) begin
            // Divide by zero finishes one edge after acceptance.
            state   <= DONE;
            done_r  <= 1'b1;
            dz_pend <= 1'b0;
            dbz_r   <= 1'b1;
            quo_r   <= DZ_QUOTIENT[WIDTH-1:0];
            rem_r   <= dvd_w;
          end else if (accept) begin
            if (bus.divisor == '0) begin
              state   <= IDLE;
              dz_pend <= 1'b1;
            end else begin
              state  <= CALC;
              busy_r <= 1'b1;
              cnt    <= CW'(WIDTH - 1);
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (cnt == '0) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            dbz_r  <= 1'b0;
            quo_r  <= cond_neg(q_next, neg_q);
            rem_r  <= cond_neg(step_r, neg_r);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divmod.sv
// Directed plus random bench for seq_divmod (WIDTH=16). Expected results come
// from a plain-arithmetic model of division; timing from the handshake rules.
module tb_seq_divmod;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  seq_divmod_if #(.WIDTH(16)) bus ();

  seq_divmod #(.WIDTH(16)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: quotient/remainder from ordinary integer arithmetic.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       output logic [15:0] q, output logic [15:0] r, output logic dz);
    int sa, sb, sq, sr;
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; dz = 1'b1;
    end else if (sm) begin
      sa = $signed(a); sb = $signed(b);
      sq = sa / sb;    sr = sa % sb;
      q  = sq[15:0];   r  = sr[15:0]; dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  // Issue one operation from a point just after a rising edge and follow it
  // to done. glitch >= 0 pulses a competing start at that cycle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       input int glitch, output logic [15:0] q_o, output logic [15:0] r_o);
    logic [15:0] eq, er;
    logic        edz;
    int          lat;
    model(a, b, sm, eq, er, edz);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
`ifdef SEQ_DIVMOD_SIGNED_EN
    bus.signed_mode = sm;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      chk("busy_during_op", {31'd0, bus.busy}, {31'd0, ~edz});
      if (lat == glitch) begin
        bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd3;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
    chk("latency", lat, edz ? 1 : 16);
    chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
    chk("quotient", {16'd0, bus.quotient}, {16'd0, eq});
    chk("remainder", {16'd0, bus.remainder}, {16'd0, er});
    chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, edz});
    q_o = bus.quotient;
    r_o = bus.remainder;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_done", {31'd0, bus.done}, 32'd0);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] q, r, a, b;
    logic        sm;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
`ifdef SEQ_DIVMOD_SIGNED_EN
    bus.signed_mode = 1'b0;
`endif
    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_quot", {16'd0, bus.quotient}, 32'd0);
    chk("rst_rem", {16'd0, bus.remainder}, 32'd0);
    chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    do_op(16'd100, 16'd7, 1'b0, -1, q, r);
    chk("plan_100_7_q", {16'd0, q}, 32'd14);
    chk("plan_100_7_r", {16'd0, r}, 32'd2);
    idle_check(2);

    do_op(16'd5, 16'd0, 1'b0, -1, q, r);
    chk("plan_5_0_q", {16'd0, q}, 32'hFFFF);
    chk("plan_5_0_r", {16'd0, r}, 32'd5);
    idle_check(2);

    // Back-to-back: second start is presented in the DONE cycle.
    do_op(16'hFFFF, 16'd1, 1'b0, -1, q, r);
    chk("b2b_first_q", {16'd0, q}, 32'hFFFF);
    chk("b2b_first_r", {16'd0, r}, 32'd0);
    do_op(16'h1234, 16'h0010, 1'b0, -1, q, r);
    chk("b2b_second_q", {16'd0, q}, 32'h0123);
    chk("b2b_second_r", {16'd0, r}, 32'd4);
    idle_check(2);

    // Start pulsed mid-CALC must be ignored.
    do_op(16'd50, 16'd5, 1'b0, 3, q, r);
    chk("glitch_q", {16'd0, q}, 32'd10);
    chk("glitch_r", {16'd0, r}, 32'd0);
    idle_check(20);

    // Reset five cycles into an operation.
    bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 16'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_quot", {16'd0, bus.quotient}, 32'd0);
    chk("abort_rem", {16'd0, bus.remainder}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle_check(20);
    do_op(16'd1000, 16'd3, 1'b0, -1, q, r);
    chk("after_abort_q", {16'd0, q}, 32'd333);
    chk("after_abort_r", {16'd0, r}, 32'd1);
    idle_check(1);

`ifdef SEQ_DIVMOD_SIGNED_EN
    do_op(16'hFFF9, 16'd2, 1'b1, -1, q, r);
    chk("s_m7_2_q", {16'd0, q}, 32'hFFFD);
    chk("s_m7_2_r", {16'd0, r}, 32'hFFFF);
    do_op(16'h8000, 16'hFFFF, 1'b1, -1, q, r);
    chk("s_min_m1_q", {16'd0, q}, 32'h8000);
    chk("s_min_m1_r", {16'd0, r}, 32'd0);
    do_op(16'hFFF0, 16'd0, 1'b1, -1, q, r);
    chk("s_dz_r", {16'd0, r}, 32'hFFF0);
    idle_check(1);
`endif

    // Random operations, some with zero divisor, some back-to-back.
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
`ifdef SEQ_DIVMOD_SIGNED_EN
      sm = 1'($urandom_range(0, 1));
`else
      sm = 1'b0;
`endif
      do_op(a, b, sm, -1, q, r);
      if ($urandom_range(0, 1) == 0) idle_check(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_divmod.md
# seq_divmod

Parametrised multi-cycle divider for the 16-bit CPU datapath that returns quotient and remainder (modulo) together. One restoring-division step runs per clock under a start/done handshake, and the result is held until the next operation. The ALU issues DIV/MOD operations here and stalls on `busy`. This replaces the single-cycle combinational modulo path.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width, in bits. Must be at least 2.

Ports:
- `Clock`, in, 1: single clock; all state updates on the rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request a new operation. Sampled only when the block can accept.
- `dividend`, in, WIDTH: numerator. Captured on the accepting edge.
- `divisor`, in, WIDTH: denominator. Captured on the accepting edge.
- `signed_mode`, in, 1: present only with `SEQ_DIVMOD_SIGNED_EN`. 1 selects two's-complement operation. Captured on the accepting edge.
- `busy`, out, 1: operation in progress. A new `start` is ignored while high.
- `done`, out, 1: one-cycle pulse marking the cycle in which results become valid.
- `quotient`, out, WIDTH: held result.
- `remainder`, out, WIDTH: held result (the modulo).
- `div_by_zero`, out, 1: flag for the held result; the divisor was 0.

## Operation
- States are IDLE, CALC and DONE.
- IDLE, or DONE, with `start`=1:
  - Capture the operands.
  - If `divisor`==0, go to DONE and skip CALC.
  - Otherwise load the working registers, set the step counter to WIDTH-1 and go to CALC.
- CALC, one restoring step per edge, on the partial remainder R and partial quotient Q:
  - Shift R left by one and bring in the next dividend bit, MSB first.
  - Compute the trial difference T = R - divisor, at WIDTH+1 bits.
  - If T ≥ 0, set R = T and shift 1 into Q; otherwise keep R and shift 0 into Q.
- CALC exit: on the edge that processes bit 0, load `quotient`/`remainder`, go to DONE and assert `done`.
- DONE: `done`=1 for exactly this one cycle. Without `start`, go to IDLE on the next edge.
- `start` asserted in DONE is accepted, so back-to-back operations have no idle gap.
- `start` in CALC is ignored and the operands are not sampled.
- Divide by zero:
  - `quotient` = all ones, `remainder` = `dividend`, `div_by_zero` = 1.
  - The normal unsigned path clears `div_by_zero`.
- Results and `div_by_zero` hold their values until the next operation's DONE load. They are not cleared at start.
- Width rules:
  - The internal trial subtraction is WIDTH+1 bits wide, with the carry out used as the sign.
  - The counter is $clog2(WIDTH) bits wide.
  - No output ever carries more than WIDTH bits.

## Timing
- Reset values, asynchronous and effective immediately:
  - state = IDLE
  - `busy`=0, `done`=0, `div_by_zero`=0
  - `quotient`=0, `remainder`=0
- Let edge k be the edge that accepts `start`:
  - `busy`=1 from after edge k through after edge k+WIDTH-1.
  - `done`=1 and results are valid after edge k+WIDTH, i.e. a latency of WIDTH cycles.
  - `busy`=0 in the DONE cycle.
- Divide by zero: `done`=1 after edge k+1 (latency 1). `busy` stays 0 throughout.
- Reset asserted mid-CALC aborts the operation. No `done` is produced and outputs return to their reset values.
- `busy` and `done` are never high in the same cycle.

## Configuration
- Macro: `SEQ_DIVMOD_SIGNED_EN`.
- Without the macro:
  - Unsigned only.
  - No `signed_mode` port.
- With the macro, `signed_mode` exists, and when `signed_mode`=1:
  - Operands are converted to magnitudes at capture.
  - Signs are fixed up on the final CALC edge, so latency is unchanged.
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - MIN / -1 gives `quotient`=MIN and `remainder`=0.
  - Divide by zero gives `quotient` = all ones and `remainder` = `dividend`.

## Structure
- Shared package `seq_divmod_pkg` holds:
  - the state enum (IDLE/CALC/DONE);
  - the default WIDTH constant, 16;
  - the divide-by-zero quotient constant (all ones).
- Sub-module `divmod_step` is the combinational restoring step:
  - inputs: R, next dividend bit, divisor;
  - outputs: new R and quotient bit.
- The top level holds the FSM, the counter, the operand/result registers and the sign handling.

## Test plan
Unless stated otherwise, WIDTH=16.
- 100 / 7 → after 16 cycles: `done`, `quotient`=14, `remainder`=2, `div_by_zero`=0.
- 5 / 0 → after 1 cycle: `done`, `quotient`=0xFFFF, `remainder`=5, `div_by_zero`=1, `busy` never high.
- 0xFFFF / 1, then `start` held in DONE with 0x1234 / 0x10:
  - first result: `quotient`=0xFFFF, `remainder`=0;
  - second result: `done` exactly 16 cycles later, `quotient`=0x0123, `remainder`=4.
- 50 / 5 started, then `start` pulsed mid-CALC with 9 / 3 → the pulse is ignored, and the only `done` gives `quotient`=10, `remainder`=0.
- Reset asserted 5 cycles into 1000 / 3:
  - immediately: all outputs 0, no `done`;
  - next 1000 / 3 → `quotient`=333, `remainder`=1.
- `SEQ_DIVMOD_SIGNED_EN`, `signed_mode`=1:
  - -7 / 2 → `quotient`=0xFFFD, `remainder`=0xFFFF;
  - 0x8000 / 0xFFFF → `quotient`=0x8000, `remainder`=0.
